// File: rtl/sweep_ctrl_pkg.sv
// Shared state encodings and default widths for the sweep sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam int DIV_W_DEF   = 16;
  localparam int COUNT_W_DEF = 8;

endpackage

// File: rtl/sweep_ctrl_step_prescaler.sv
// Step prescaler: counts 0..div while run is high and flags the terminal count.
// Latency: tick is combinational from the current count; the count updates on the edge.
// Backpressure: run low freezes the count in place; clr has priority and zeroes it.
module sweep_ctrl_step_prescaler
  import sweep_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rstna,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;

  // Terminal count only matters while the caller lets the count advance.
  assign tick = run && (cnt == div);

  // Free count 0..div; holds its value whenever run is low so a pause resumes mid-period.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == div) ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: paces the shift-register step enable, counts TC pulses, stops on target or command.
// Latency: first sr_ena div+1 clocks after start is taken; done/aborted one clock after the deciding edge.
// Backpressure: hold freezes stepping (PAUSE); stop aborts; start is ignored unless IDLE.
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rstna,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic [DIV_W-1:0]   step_div,
  input  logic [COUNT_W-1:0] n_periods,
  input  logic               tc_in,
  output logic               sr_ena,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] periods_done
);

  localparam logic [COUNT_W-1:0] ONE_C = COUNT_W'(1);

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [COUNT_W-1:0] target_q;
  logic [COUNT_W-1:0] pd_inc;
  logic               active;
  logic               accept;
  logic               complete;
  logic               pre_run;
  logic               tick;

  assign active   = (state == S_RUN) || (state == S_PAUSE);
  assign accept   = (state == S_IDLE) && start && !stop;
  assign pd_inc   = periods_done + ONE_C;
  // Final TC of a bounded run; a zero target means run until stopped.
  assign complete = active && !stop && tc_in && (target_q != '0) && (pd_inc == target_q);
  // Prescaler advances only in RUN and only when nothing of higher priority claims the cycle.
  assign pre_run  = (state == S_RUN) && !stop && !complete && !hold;

  sweep_ctrl_step_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rstna (rstna),
    .clr   (accept),
    .run   (pre_run),
    .div   (div_q),
    .tick  (tick)
  );

  // Control FSM with registered outputs; priority stop > completion > hold > step.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      state        <= S_IDLE;
      div_q        <= '0;
      target_q     <= '0;
      periods_done <= '0;
      sr_ena       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      sr_ena  <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            div_q        <= step_div;
            target_q     <= n_periods;
            periods_done <= '0;
            state        <= S_RUN;
            busy         <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN, S_PAUSE: begin
          // A TC seen while running is always counted, even on the cycle that ends the run.
          if (tc_in) begin
            periods_done <= pd_inc;
          end
          if (stop) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (complete) begin
            state <= S_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (hold) begin
            state <= S_PAUSE;
            busy  <= 1'b1;
          end else begin
            state  <= S_RUN;
            busy   <= 1'b1;
            sr_ena <= tick;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench: sweep_ctrl driving a behavioural 8-bit bouncing one-hot register.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: hold/stop/start exercised as directed steps with hand-computed timings.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rstna;
  logic        start;
  logic        stop;
  logic        hold;
  logic [15:0] step_div;
  logic [7:0]  n_periods;
  logic        tc_in = 1'b0;
  logic        sr_ena;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  periods_done;

  int checks = 0;
  int errors = 0;

  sweep_ctrl dut (
    .clk          (clk),
    .rstna        (rstna),
    .start        (start),
    .stop         (stop),
    .hold         (hold),
    .step_div     (step_div),
    .n_periods    (n_periods),
    .tc_in        (tc_in),
    .sr_ena       (sr_ena),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .periods_done (periods_done)
  );

  always #5 clk = ~clk;

  // Bouncing one-hot register, 8 bits: token walks 0..7..0; TC one clock after reaching an end,
  // so a TC follows every 7 steps.
  logic sr_clr = 1'b0;
  int   sr_pos = 0;
  logic sr_up  = 1'b1;
  int   sr_steps = 0;

  always @(posedge clk) begin
    if (sr_clr || !rstna) begin
      sr_pos   <= 0;
      sr_up    <= 1'b1;
      sr_steps <= 0;
      tc_in    <= 1'b0;
    end else begin
      tc_in <= 1'b0;
      if (sr_ena) begin
        sr_steps <= sr_steps + 1;
        if (sr_up) begin
          sr_pos <= sr_pos + 1;
          if (sr_pos + 1 == 7) begin
            sr_up <= 1'b0;
            tc_in <= 1'b1;
          end
        end else begin
          sr_pos <= sr_pos - 1;
          if (sr_pos - 1 == 0) begin
            sr_up <= 1'b1;
            tc_in <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sr_reset();
    sr_clr = 1'b1;
    cyc();
    sr_clr = 1'b0;
  endtask

  // Returns just after the edge that accepts start (RUN entry, t = 0).
  task automatic do_start(input logic [15:0] d, input logic [7:0] n);
    step_div  = d;
    n_periods = n;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int pulses;
    int bad;
    int done_t;
    int done_cnt;
    int tcs;
    int rel;
    int hold_ena;

    rstna = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    step_div = '0; n_periods = '0;
    repeat (3) cyc();

    // Reset state
    chk("rst_sr_ena", 32'(sr_ena), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_periods_done", 32'(periods_done), 32'd0);
    rstna = 1'b1;
    cyc();

    // 1: div=3, n=2. Pulses at t=4,8,..; TC #1 counted at t=30; 14th pulse t=56, done at t=58.
    sr_reset();
    do_start(16'd3, 8'd2);
    first = -1; pulses = 0; bad = 0; done_t = -1;
    for (int t = 1; t <= 120 && done_t < 0; t++) begin
      cyc();
      if (sr_ena) begin
        pulses++;
        if (first < 0) first = t;
        if (t % 4 != 0) bad++;
      end
      if (t == 31) chk("t1_pd_after_tc1", 32'(periods_done), 32'd1);
      if (done) begin
        done_t = t;
        chk("t1_busy_in_finish", 32'(busy), 32'd0);
        chk("t1_sr_ena_at_done", 32'(sr_ena), 32'd0);
      end
    end
    chk("t1_first_sr_ena", 32'(first), 32'd4);
    chk("t1_pulse_count", 32'(pulses), 32'd14);
    chk("t1_off_grid_pulses", 32'(bad), 32'd0);
    chk("t1_done_time", 32'(done_t), 32'd58);
    chk("t1_periods_done", 32'(periods_done), 32'd2);
    cyc();
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_sr_ena_after", 32'(sr_ena), 32'd0);

    // 2: div=0, n=1. sr_ena high t=1..8; FINISH at t=9 while one more step lands (8 steps, pos 6).
    sr_reset();
    do_start(16'd0, 8'd1);
    pulses = 0; done_cnt = 0; done_t = -1;
    for (int t = 1; t <= 20; t++) begin
      cyc();
      if (sr_ena) pulses++;
      if (done) begin
        done_cnt++;
        done_t = t;
      end
    end
    chk("t2_sr_ena_high_cycles", 32'(pulses), 32'd8);
    chk("t2_done_count", 32'(done_cnt), 32'd1);
    chk("t2_done_time", 32'(done_t), 32'd9);
    chk("t2_sr_steps", 32'(sr_steps), 32'd8);
    chk("t2_sr_pos", 32'(sr_pos), 32'd6);
    chk("t2_periods_done", 32'(periods_done), 32'd1);

    // 3: continuous, div=1; stop after 5 TCs.
    sr_reset();
    do_start(16'd1, 8'd0);
    tcs = 0; done_cnt = 0;
    for (int t = 1; t <= 200 && tcs < 5; t++) begin
      cyc();
      if (done) done_cnt++;
      if (tc_in) tcs++;
    end
    chk("t3_tc_seen", 32'(tcs), 32'd5);
    cyc();
    if (done) done_cnt++;
    chk("t3_pd_before_stop", 32'(periods_done), 32'd5);
    chk("t3_busy_before_stop", 32'(busy), 32'd1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    if (done) done_cnt++;
    chk("t3_aborted", 32'(aborted), 32'd1);
    chk("t3_busy_after_stop", 32'(busy), 32'd0);
    chk("t3_sr_ena_after_stop", 32'(sr_ena), 32'd0);
    chk("t3_pd_kept", 32'(periods_done), 32'd5);
    cyc();
    if (done) done_cnt++;
    chk("t3_aborted_one_cycle", 32'(aborted), 32'd0);
    chk("t3_done_never", 32'(done_cnt), 32'd0);

    // 5a: start with stop in IDLE is ignored; periods_done is not cleared.
    step_div = 16'd2; n_periods = 8'd1;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("t5a_busy", 32'(busy), 32'd0);
    cyc();
    chk("t5a_busy_later", 32'(busy), 32'd0);
    chk("t5a_sr_ena", 32'(sr_ena), 32'd0);
    chk("t5a_pd_unchanged", 32'(periods_done), 32'd5);

    // 4: div=3, hold sampled while count=2 (after t=6), held 10 clocks.
    sr_reset();
    do_start(16'd3, 8'd0);
    for (int t = 1; t <= 6; t++) begin
      cyc();
      if (t == 4) chk("t4_first_sr_ena", 32'(sr_ena), 32'd1);
    end
    hold = 1'b1;
    hold_ena = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (sr_ena) hold_ena++;
    end
    chk("t4_no_sr_ena_in_hold", 32'(hold_ena), 32'd0);
    chk("t4_busy_in_pause", 32'(busy), 32'd1);
    hold = 1'b0;
    // One edge to re-enter RUN, then count 2->3 and the step: 1 + 2 edges.
    rel = -1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (sr_ena && rel < 0) rel = k;
    end
    chk("t4_release_to_sr_ena", 32'(rel), 32'd3);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t4_aborted", 32'(aborted), 32'd1);

    // 5b: start during RUN with a new div is ignored; rate stays one step per 2 clocks.
    sr_reset();
    do_start(16'd1, 8'd0);
    cyc();
    chk("t5b_sr_ena_t1", 32'(sr_ena), 32'd0);
    cyc();
    chk("t5b_sr_ena_t2", 32'(sr_ena), 32'd1);
    step_div = 16'd5; n_periods = 8'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (sr_ena) pulses++;
    end
    chk("t5b_pulses_in_6", 32'(pulses), 32'd3);
    chk("t5b_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();

    // 6: async reset mid-run. div=1: pulses on even t, first TC counted at t=16.
    sr_reset();
    do_start(16'd1, 8'd0);
    repeat (20) cyc();
    chk("t6_pd_before_rst", 32'(periods_done), 32'd1);
    chk("t6_sr_ena_before_rst", 32'(sr_ena), 32'd1);
    #2;
    rstna = 1'b0;
    #1;
    chk("t6_sr_ena_async", 32'(sr_ena), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    chk("t6_pd_async", 32'(periods_done), 32'd0);
    @(negedge clk);
    rstna = 1'b1;
    cyc();
    cyc();
    chk("t6_busy_after", 32'(busy), 32'd0);
    chk("t6_sr_ena_after", 32'(sr_ena), 32'd0);
    chk("t6_pd_after", 32'(periods_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
